// File: rtl/step_chk_pkg.sv
// Shared types and constants for the step stream checker.
package step_chk_pkg;

    // Width of the saturating error total.
    localparam int unsigned ErrCntWidth = 16;

    // Width of the RESYNC run counter (LOCK_CNT is limited to 1..255).
    localparam int unsigned RunCntWidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StResync
    } chk_state_e;

endpackage

// File: rtl/step_err_sat_counter.sv
// Saturating up-counter for detected errors; clr has priority over inc.
module step_err_sat_counter
    import step_chk_pkg::*;
#(
    parameter int unsigned Width = ErrCntWidth
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             clr,
    output logic [Width-1:0] count
);

    // Count up on inc, stick at all-ones, zero on clr or reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {Width{1'b1}})) begin
            count <= count + Width'(1);
        end
    end

endmodule

// File: rtl/step_stream_checker.sv
// Checks that an incoming counter stream advances by STEP per accepted beat,
// tracking lock, flagging errors and re-locking after LOCK_CNT good beats.
module step_stream_checker
    import step_chk_pkg::*;
#(
    parameter int unsigned STEP     = 2,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic [31:0]            in_data,
    output logic                   in_ready,
    output logic                   locked,
    output logic                   err_pulse,
    output logic [ErrCntWidth-1:0] err_count,
    output logic [31:0]            expected
);

    localparam logic [31:0]            StepW     = 32'(STEP);
    localparam logic [RunCntWidth-1:0] LockW     = RunCntWidth'(LOCK_CNT);
    // With an even step every legal value is even, so an odd beat is always bad.
    localparam bit                     ParityChk = ((STEP % 2) == 0);

    chk_state_e             state_q;
    logic [RunCntWidth-1:0] run_cnt_q;
    logic [RunCntWidth-1:0] run_inc;
    logic                   accept;
    logic                   odd_bad;
    logic                   match;
    logic                   err_det;

    // Ready is dropped during reset and whenever clr is asserted, so clr beats a beat.
    assign in_ready = ~RST & ~clr;
    assign accept   = in_valid & in_ready;
    assign odd_bad  = ParityChk & in_data[0];
    assign match    = (in_data == expected) & ~odd_bad;
    assign run_inc  = run_cnt_q + RunCntWidth'(1);

    // Classify the current beat as an error for the state it arrives in.
    always_comb begin
        err_det = 1'b0;
        if (accept) begin
            if (state_q == StIdle) begin
                err_det = odd_bad;
            end else begin
                err_det = ~match;
            end
        end
    end

    // Tracking FSM with registered locked/err_pulse/expected outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            expected  <= '0;
            run_cnt_q <= '0;
        end else if (clr) begin
            state_q   <= StIdle;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            expected  <= '0;
            run_cnt_q <= '0;
        end else begin
            err_pulse <= err_det;
            if (accept) begin
                case (state_q)
                    StIdle: begin
                        if (!odd_bad) begin
                            expected <= in_data + StepW;
                            state_q  <= StTrack;
                            locked   <= 1'b1;
                        end
                    end
                    StTrack: begin
                        if (match) begin
                            expected <= expected + StepW;
                        end else begin
                            expected  <= in_data + StepW;
                            run_cnt_q <= '0;
                            state_q   <= StResync;
                            locked    <= 1'b0;
                        end
                    end
                    StResync: begin
                        if (match) begin
                            expected <= expected + StepW;
                            if (run_inc == LockW) begin
                                run_cnt_q <= '0;
                                state_q   <= StTrack;
                                locked    <= 1'b1;
                            end else begin
                                run_cnt_q <= run_inc;
                            end
                        end else begin
                            // Restart the run from the offending value.
                            expected  <= in_data + StepW;
                            run_cnt_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

    step_err_sat_counter #(
        .Width(ErrCntWidth)
    ) u_err_cnt (
        .CLK  (CLK),
        .RST  (RST),
        .inc  (err_det),
        .clr  (clr),
        .count(err_count)
    );

endmodule
